mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port unified RAM between the pipeline's instruction-fetch
//   (IF) stage and data-access (MEM) stage. Serialises requests, issues them to
//   the RAM with fixed read latency, and returns a one-cycle ready pulse.
//   The pipeline stalls a stage while its req is high and its ready is low.
// PARAMETERS
//   RAM_LATENCY   1   cycles from the ram_en cycle to valid ram_rdata (>=1)
//   RAM_AW        10  RAM word-address width; byte address bits [RAM_AW+1:2] used
//   STARVE_LIMIT  4   consecutive data grants allowed while IF waits (>=1)
// PORTS
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous reset, active-high
//   if_req     in   1       fetch request; held until if_ready
//   if_addr    in   32      fetch byte address; held stable while if_req
//   if_flush   in   1       cancel in-flight fetch (branch taken / redirect)
//   if_rdata   out  32      fetched instruction; valid when if_ready
//   if_ready   out  1       one-cycle fetch completion pulse
//   dm_req     in   1       data request; held until dm_ready
//   dm_we      in   1       1 = store, 0 = load; stable while dm_req
//   dm_addr    in   32      data byte address; stable while dm_req
//   dm_wdata   in   32      store data; stable while dm_req
//   dm_rdata   out  32      load data; valid when dm_ready
//   dm_ready   out  1       one-cycle data completion pulse
//   ram_en     out  1       RAM access strobe, exactly one cycle per access
//   ram_we     out  1       RAM write enable, qualified by ram_en
//   ram_addr   out  RAM_AW  RAM word address
//   ram_wdata  out  32      RAM write data
//   ram_rdata  in   32      RAM read data
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, counters 0; reset is async (clears mid-access,
//   ram_en drops immediately); no ready pulse is generated for an aborted access.
//   FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//   - IDLE: on edge with any req, latch winner (addr>>2 truncated to RAM_AW, we,
//     wdata, owner). Low two address bits ignored. No req: stay IDLE.
//   - ISSUE (1 cycle): ram_en=1, ram_we=dm_we for data owner, 0 for IF.
//   - WAIT: counter counts RAM_LATENCY-1 further cycles (0 when RAM_LATENCY=1);
//     ram_rdata sampled at the edge ending cycle ISSUE+RAM_LATENCY.
//   - DONE (1 cycle): owner's ready=1, rdata holds captured word (stores: dm_rdata
//     = 0). Next cycle IDLE; a held/new req is granted at that IDLE edge.
//   Timing (RAM_LATENCY=1): req seen cycle 0, ram_en cycle 1, ready cycle 3;
//   throughput one access per RAM_LATENCY+3 cycles.
//   Arbitration: dm_req wins over if_req (older instruction). starve counter
//   increments per data grant while if_req is high, clears on IF grant or when
//   if_req low; at STARVE_LIMIT, IF wins the next grant regardless of dm_req.
//   Flush: if_flush high any cycle while IF owns ISSUE/WAIT/DONE -> RAM access
//   completes, if_ready suppressed (stays 0), if_rdata unchanged. if_flush in
//   IDLE has no effect beyond that cycle (the fetcher drops/changes req itself).
//   Requester dropping req mid-access: access completes, ready still pulses.
//   Outputs if_rdata/dm_rdata hold last value until next completion for owner.
// TESTING
//   1 Reset: rst=1 mid-WAIT -> ram_en, if_ready, dm_ready 0 same cycle; IDLE after.
//   2 Single fetch, LAT=1: if_req, if_addr=0x0000_0008, RAM word 2=0x2009_0005
//     -> ram_en cycle 1 with ram_addr=2, if_ready cycle 3, if_rdata=0x2009_0005.
//   3 Store then load: dm_we=1 addr 0x40 wdata 0x0000_000A, then load 0x40 ->
//     ram_we=1 on first ISSUE only, second dm_rdata=0x0000_000A.
//   4 Contention: if_req and dm_req both high from cycle 0 -> data granted first,
//     fetch granted at the IDLE following dm_ready; no cycle with both readys.
//   5 Starvation, STARVE_LIMIT=4: dm_req held continuously plus if_req -> exactly
//     4 dm_ready pulses, then if_ready, then data resumes.
//   6 Flush: if_flush pulsed during WAIT of a fetch -> one ram_en, no if_ready,
//     if_rdata unchanged; following fetch to 0x0C completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between the fetch and data stages
module mem_port_arbiter #(
    parameter int RAM_LATENCY  = 1,
    parameter int RAM_AW       = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam int CW = RAM_LATENCY > 1 ? $clog2(RAM_LATENCY) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [SW-1:0]     starve;
    logic              owner_if, we_q, flushed, pick_if, grant, lat_done;
    logic [RAM_AW-1:0] addr_q;
    logic [31:0]       wdata_q, cap, if_rdata_q;
    logic              unused;
    assign unused   = ^{if_addr[31:RAM_AW+2], if_addr[1:0], dm_addr[31:RAM_AW+2], dm_addr[1:0]};
    // Data normally wins; fetch wins when it is alone or has waited STARVE_LIMIT data grants
    assign pick_if  = if_req && (!dm_req || starve >= SW'(STARVE_LIMIT));
    assign grant    = state == IDLE && (if_req || dm_req);
    assign lat_done = state == WAIT && cnt == CW'(RAM_LATENCY - 1);
    assign ram_en    = state == ISSUE;
    assign ram_we    = ram_en && we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign if_ready  = state == DONE && owner_if && !flushed && !if_flush;
    assign dm_ready  = state == DONE && !owner_if;
    assign if_rdata  = if_ready ? cap : if_rdata_q;
    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // Next state: one ISSUE cycle, RAM_LATENCY WAIT cycles, one DONE cycle
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE  ? (grant ? ISSUE : IDLE) :
                   state == ISSUE ? WAIT :
                   state == WAIT  ? (lat_done ? DONE : WAIT) : IDLE;
    end
    // Latch the winning request at the grant edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_if <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (grant) begin
            owner_if <= pick_if;
            we_q     <= !pick_if && dm_we;
            addr_q   <= pick_if ? if_addr[RAM_AW+1:2] : dm_addr[RAM_AW+1:2];
            wdata_q  <= pick_if ? '0 : dm_wdata;
        end
    end
    // Latency counter, flush tracking and starvation counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            flushed <= 1'b0;
            starve  <= '0;
        end else begin
            cnt     <= state == ISSUE ? '0 : (state == WAIT && !lat_done) ? cnt + 1'b1 : cnt;
            flushed <= grant ? 1'b0 :
                       (owner_if && if_flush && (state == ISSUE || state == WAIT)) ? 1'b1 : flushed;
            starve  <= !if_req ? '0 : grant ? (pick_if ? '0 : starve + 1'b1) : starve;
        end
    end
    // Capture read data; each port's rdata only changes on its own completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap        <= '0;
            dm_rdata   <= '0;
            if_rdata_q <= '0;
        end else begin
            if (lat_done) cap <= ram_rdata;
            if (lat_done && !owner_if) dm_rdata <= we_q ? '0 : ram_rdata;
            if (if_ready) if_rdata_q <= cap;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the fetch/data RAM arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, ram_rdata = '0;
    logic [31:0] if_rdata, dm_rdata, ram_wdata;
    logic        if_ready, dm_ready, ram_en, ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] mem [0:1023];
    typedef struct packed {logic port_if; logic [31:0] data;} exp_t;
    exp_t        sb[$];
    exp_t        e_m;
    int          n_cmp = 0, n_err = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // One-cycle-latency synchronous RAM
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= mem[ram_addr];
            if (ram_we) mem[ram_addr] = ram_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Completion monitor: every ready pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && (if_ready || dm_ready)) begin
            if (if_ready && dm_ready) check("both_ready", 1, 0);
            if (sb.size() == 0) check("unexpected_ready", 1, 0);
            else begin
                e_m = sb.pop_front();
                check("ready_port", {31'b0, if_ready}, {31'b0, e_m.port_if});
                check("ready_data", if_ready ? if_rdata : dm_rdata, e_m.data);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_at(input int n);
        idle(2);
        if_req = 1'b1; if_addr = 32'h8;
        repeat (n) @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("rst_ram_en", ram_en, 0);
        check("rst_if_ready", if_ready, 0);
        check("rst_dm_ready", dm_ready, 0);
        if_req = 1'b0;
        @(negedge clk) rst = 1'b0;
        repeat (5) @(negedge clk) check("post_rst_en", ram_en, 0);
        check("post_rst_if_rdata", if_rdata, 0);
    endtask

    task automatic fetch_timed(input logic [31:0] a, input logic [31:0] d);
        sb.push_back('{port_if: 1'b1, data: d});
        if_req = 1'b1; if_addr = a;
        @(negedge clk); check("c0_ram_en", ram_en, 0);
        @(negedge clk); check("c1_ram_en", ram_en, 1);
        check("c1_ram_addr", {22'b0, ram_addr}, {22'b0, a[11:2]});
        check("c1_ram_we", ram_we, 0);
        @(negedge clk); check("c2_if_ready", if_ready, 0);
        @(negedge clk); check("c3_if_ready", if_ready, 1);
        @(posedge clk); #1 if_req = 1'b0;
    endtask

    task automatic dm_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] d);
        bit done = 0;
        sb.push_back('{port_if: 1'b0, data: d});
        dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (ram_en) begin
                check("dm_ram_we", ram_we, we);
                if (we) check("dm_ram_wdata", ram_wdata, wd);
            end
            if (dm_ready) done = 1;
        end
        if (!done) check("dm_timeout", 0, 1);
        @(posedge clk); #1 dm_req = 1'b0; dm_we = 1'b0;
    endtask

    initial begin
        int tdm, tif, n, en_cnt;
        bit got_if;
        mem[2] = 32'h2009_0005; mem[3] = 32'h0C0C_0C0C;
        mem[5] = 32'h1111_2222; mem[8] = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rst_en", ram_en, 0);
        check("rst_ifr", if_ready, 0);
        check("rst_dmr", dm_ready, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        @(negedge clk) rst = 1'b0;
        for (int k = 1; k <= 3; k++) reset_at(k);
        idle(2);
        fetch_timed(32'h8, 32'h2009_0005);
        idle(1);
        dm_access(1'b1, 32'h40, 32'h0000_000A, 32'h0);
        idle(1);
        dm_access(1'b0, 32'h43, 32'h0, 32'h0000_000A);
        idle(2);
        sb.push_back('{port_if: 1'b0, data: 32'hA});
        sb.push_back('{port_if: 1'b1, data: 32'h1111_2222});
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; if_req = 1'b1; if_addr = 32'h14;
        tdm = -1; tif = -1;
        for (int c = 0; c < 30 && tif < 0; c++) begin
            @(negedge clk);
            if (dm_ready) tdm = c;
            if (if_ready) tif = c;
            @(posedge clk); #1;
            if (tdm == c) dm_req = 1'b0;
            if (tif == c) if_req = 1'b0;
        end
        check("contend_dm_cycle", tdm, 3);
        check("contend_if_cycle", tif, 7);
        idle(2);
        for (int k = 0; k < 4; k++) sb.push_back('{port_if: 1'b0, data: 32'hA});
        sb.push_back('{port_if: 1'b1, data: 32'h1111_2222});
        sb.push_back('{port_if: 1'b0, data: 32'hA});
        dm_req = 1'b1; dm_addr = 32'h40; if_req = 1'b1; if_addr = 32'h14; n = 0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(negedge clk);
            got_if = if_ready;
            if (if_ready || dm_ready) n++;
            @(posedge clk); #1;
            if (got_if) if_req = 1'b0;
            if (n == 6) dm_req = 1'b0;
        end
        dm_req = 1'b0; if_req = 1'b0;
        check("starve_count", n, 6);
        idle(2);
        if_req = 1'b1; if_addr = 32'h20; en_cnt = 0;
        @(negedge clk) en_cnt += int'(ram_en);
        @(negedge clk) en_cnt += int'(ram_en);
        @(posedge clk); #1 if_flush = 1'b1; if_req = 1'b0;
        @(posedge clk); #1 if_flush = 1'b0;
        repeat (4) @(negedge clk) begin
            en_cnt += int'(ram_en);
            check("flush_if_ready", if_ready, 0);
        end
        check("flush_en_count", en_cnt, 1);
        check("flush_if_rdata", if_rdata, 32'h1111_2222);
        idle(1);
        fetch_timed(32'h0C, 32'h0C0C_0C0C);
        idle(3);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
